// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between the WB
// stage (always wins) and the mult/div unit. MDU results that cannot write
// right away wait in an in-order queue whose live entries also serve as a
// pending-write scoreboard for the ID stage.
// Optional build macro: MDU_DIRECT_EN -- with an empty queue and idle WB, an
// accepted MDU result goes straight to the write port without being queued.
module regfile_write_arbiter #(
   parameter int DEPTH      = 4,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int STARVE_MAX = 8
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              WbValid,
   input  logic [ADDR_W-1:0] WbReg,
   input  logic [DATA_W-1:0] WbData,
   input  logic              MduValid,
   input  logic [ADDR_W-1:0] MduReg,
   input  logic [DATA_W-1:0] MduData,
   output logic              MduReady,
   input  logic [ADDR_W-1:0] QueryReg1,
   input  logic [ADDR_W-1:0] QueryReg2,
   output logic              Pending1,
   output logic              Pending2,
   output logic              StallReq,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0] WriteData
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int SC_W  = $clog2(STARVE_MAX + 1);

   // queue storage: one live bit, destination and data per slot
   logic [DEPTH-1:0]             qLive;
   logic [DEPTH-1:0][ADDR_W-1:0] qReg;
   logic [DEPTH-1:0][DATA_W-1:0] qData;
   logic [PTR_W-1:0]             rdPtr;
   logic [PTR_W-1:0]             wrPtr;
   logic [CNT_W-1:0]             count;
   logic [SC_W-1:0]              starveCnt;
   logic [SC_W-1:0]              starveNext;

   logic wbWin;
   logic queueEmpty;
   logic mduXfer;
   logic directTake;
   logic pop;
   logic push;

   // a WB write to register 0 is treated as idle so the queue can drain
   assign wbWin      = WbValid && (WbReg != '0);
   assign queueEmpty = (count == '0);
   assign MduReady   = (count != CNT_W'(DEPTH));
   assign mduXfer    = MduValid && MduReady;
   assign pop        = !wbWin && !queueEmpty;

`ifdef MDU_DIRECT_EN
   assign directTake = mduXfer && (MduReg != '0) && queueEmpty && !wbWin;
`else
   assign directTake = 1'b0;
`endif

   // results for register 0 are accepted and silently dropped
   assign push = mduXfer && (MduReg != '0) && !directTake;

   // scoreboard lookup over live queued writes; register 0 never pends
   always_comb begin
      Pending1 = 1'b0;
      Pending2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (qLive[i] && (qReg[i] == QueryReg1)) Pending1 = 1'b1;
         if (qLive[i] && (qReg[i] == QueryReg2)) Pending2 = 1'b1;
      end
      if (QueryReg1 == '0) Pending1 = 1'b0;
      if (QueryReg2 == '0) Pending2 = 1'b0;
   end

   // queue update: WAW kill of older entries, pop of head, push at tail
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         qLive <= '0;
         qReg  <= '0;
         qData <= '0;
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         // kill runs first so a same-edge push into a matching slot stays live
         if (wbWin) begin
            for (int i = 0; i < DEPTH; i++)
               if (qReg[i] == WbReg) qLive[i] <= 1'b0;
         end
         if (pop) begin
            qLive[rdPtr] <= 1'b0;
            rdPtr        <= rdPtr + PTR_W'(1);
         end
         if (push) begin
            qLive[wrPtr] <= 1'b1;
            qReg[wrPtr]  <= MduReg;
            qData[wrPtr] <= MduData;
            wrPtr        <= wrPtr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // write port: WB first, then queue head, then (optionally) direct MDU
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         RegWrite  <= 1'b0;
         WriteReg  <= '0;
         WriteData <= '0;
      end else if (wbWin) begin
         RegWrite  <= 1'b1;
         WriteReg  <= WbReg;
         WriteData <= WbData;
      end else if (pop) begin
         // a killed head just frees its slot without writing
         RegWrite <= qLive[rdPtr];
         if (qLive[rdPtr]) begin
            WriteReg  <= qReg[rdPtr];
            WriteData <= qData[rdPtr];
         end
      end else if (directTake) begin
         RegWrite  <= 1'b1;
         WriteReg  <= MduReg;
         WriteData <= MduData;
      end else begin
         RegWrite <= 1'b0;
      end
   end

   // consecutive edges where WB blocks a non-empty queue, saturating
   always_comb begin
      starveNext = '0;
      if (!queueEmpty && wbWin)
         starveNext = (starveCnt == SC_W'(STARVE_MAX)) ? starveCnt : starveCnt + SC_W'(1);
   end

   // starvation counter and registered stall request
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         starveCnt <= '0;
         StallReq  <= 1'b0;
      end else begin
         starveCnt <= starveNext;
         StallReq  <= (starveNext >= SC_W'(STARVE_MAX));
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios plus a randomized
// run, all predicted by a queue-based model of the arbitration rules.
module tb_regfile_write_arbiter;
   localparam int DEPTH = 4, DATA_W = 32, ADDR_W = 5, STARVE_MAX = 8;

   logic              Clk, Rst_n;
   logic              WbValid, MduValid, MduReady;
   logic [ADDR_W-1:0] WbReg, MduReg, QueryReg1, QueryReg2, WriteReg;
   logic [DATA_W-1:0] WbData, MduData, WriteData;
   logic              Pending1, Pending2, StallReq, RegWrite;

   regfile_write_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                           .STARVE_MAX(STARVE_MAX)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .WbValid(WbValid), .WbReg(WbReg), .WbData(WbData),
      .MduValid(MduValid), .MduReg(MduReg), .MduData(MduData), .MduReady(MduReady),
      .QueryReg1(QueryReg1), .QueryReg2(QueryReg2),
      .Pending1(Pending1), .Pending2(Pending2), .StallReq(StallReq),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // register file image, committed on negedge like the real one
   logic [DATA_W-1:0] rf [32];
   always @(negedge Clk) if (Rst_n && RegWrite) rf[WriteReg] = WriteData;

   int nvec = 0, nfail = 0;

   // reference model state
   typedef struct {logic [ADDR_W-1:0] r; logic [DATA_W-1:0] d; bit live;} ent_t;
   ent_t              mq[$];
   int                streak;
   bit                eRW, eStall, eReady, eP1, eP2;
   logic [ADDR_W-1:0] eReg;
   logic [DATA_W-1:0] eData;
   bit                oReady, oP1, oP2;

   function automatic void mreset();
      mq.delete(); streak = 0; eRW = 0; eStall = 0; eReg = '0; eData = '0;
   endfunction

   function automatic bit pend(logic [ADDR_W-1:0] q);
      if (q == '0) return 1'b0;
      foreach (mq[i]) if (mq[i].live && mq[i].r == q) return 1'b1;
      return 1'b0;
   endfunction

   // drive one cycle, sample combinational outputs pre-edge, advance model
   task automatic step(input bit wv, input logic [ADDR_W-1:0] wr, input logic [DATA_W-1:0] wd,
                       input bit mv, input logic [ADDR_W-1:0] mr, input logic [DATA_W-1:0] md,
                       input logic [ADDR_W-1:0] q1, input logic [ADDR_W-1:0] q2);
      bit wbWin, xfer, direct, pop;
      ent_t h;
      WbValid = wv; WbReg = wr; WbData = wd;
      MduValid = mv; MduReg = mr; MduData = md;
      QueryReg1 = q1; QueryReg2 = q2;
      #1;
      eReady = (mq.size() != DEPTH); eP1 = pend(q1); eP2 = pend(q2);
      oReady = MduReady; oP1 = Pending1; oP2 = Pending2;
      wbWin = wv && (wr != 0);
      xfer  = mv && eReady;
      direct = 1'b0;
`ifdef MDU_DIRECT_EN
      direct = xfer && (mr != 0) && (mq.size() == 0) && !wbWin;
`endif
      pop = !wbWin && (mq.size() != 0);
      if (mq.size() != 0 && wbWin) streak = (streak < STARVE_MAX) ? streak + 1 : streak;
      else streak = 0;
      eStall = (streak >= STARVE_MAX);
      if (wbWin) begin
         foreach (mq[i]) if (mq[i].r == wr) mq[i].live = 1'b0;
         eRW = 1; eReg = wr; eData = wd;
      end else if (pop) begin
         h = mq.pop_front();
         eRW = h.live;
         if (h.live) begin eReg = h.r; eData = h.d; end
      end else if (direct) begin
         eRW = 1; eReg = mr; eData = md;
      end else eRW = 0;
      if (xfer && mr != 0 && !direct) mq.push_back('{r: mr, d: md, live: 1'b1});
      @(posedge Clk); #1;
   endtask

   task automatic idle(input logic [ADDR_W-1:0] q1);
      step(0, '0, '0, 0, '0, '0, q1, '0);
   endtask

   task automatic test_reset();
      nvec++; if (RegWrite !== 1'b0) begin nfail++; $display("FAIL reset_rw got %b exp 0", RegWrite); end
      nvec++; if (WriteReg !== '0) begin nfail++; $display("FAIL reset_wreg got %0d exp 0", WriteReg); end
      nvec++; if (WriteData !== '0) begin nfail++; $display("FAIL reset_wdata got %h exp 0", WriteData); end
      nvec++; if (StallReq !== 1'b0) begin nfail++; $display("FAIL reset_stall got %b exp 0", StallReq); end
      nvec++; if (MduReady !== 1'b1) begin nfail++; $display("FAIL reset_ready got %b exp 1", MduReady); end
   endtask

   task automatic test_mdu_basic();
      bit rw1; logic [ADDR_W-1:0] r1; logic [DATA_W-1:0] d1;
      step(0, '0, '0, 1, 5'd8, 32'h11, 5'd8, '0);
      rw1 = RegWrite; r1 = WriteReg; d1 = WriteData;
      idle(5'd8);
`ifndef MDU_DIRECT_EN
      nvec++; if (rw1 !== 1'b0) begin nfail++; $display("FAIL mdu_early got %b exp 0", rw1); end
      nvec++; if (oP1 !== 1'b1) begin nfail++; $display("FAIL mdu_pending got %b exp 1", oP1); end
      rw1 = RegWrite; r1 = WriteReg; d1 = WriteData;
`endif
      nvec++; if (rw1 !== 1'b1 || r1 !== 5'd8 || d1 !== 32'h11) begin
         nfail++; $display("FAIL mdu_write got %b/%0d/%h exp 1/8/11", rw1, r1, d1); end
   endtask

   task automatic test_back_to_back();
      repeat (DEPTH + 1) idle('0);
      for (int i = 0; i < 4; i++) begin
         step(1, 5'(9 + i), 32'h900 + i, 1, 5'(20 + i), 32'h2000 + i, 5'd20, '0);
         nvec++; if (oReady !== 1'b1) begin nfail++; $display("FAIL b2b_ready%0d got %b exp 1", i, oReady); end
         nvec++; if (RegWrite !== 1'b1 || WriteReg !== 5'(9 + i)) begin
            nfail++; $display("FAIL b2b_wb%0d got %b/%0d exp 1/%0d", i, RegWrite, WriteReg, 9 + i); end
      end
      for (int i = 0; i < 4; i++) begin
         idle(5'd20);
         if (i == 0) begin
            nvec++; if (oReady !== 1'b0) begin nfail++; $display("FAIL b2b_full got %b exp 0", oReady); end
         end
         nvec++; if (oP1 !== (i == 0)) begin nfail++; $display("FAIL b2b_pend%0d got %b exp %b", i, oP1, i == 0); end
         nvec++; if (RegWrite !== 1'b1 || WriteReg !== 5'(20 + i) || WriteData !== 32'h2000 + i) begin
            nfail++; $display("FAIL b2b_drain%0d got %b/%0d/%h exp 1/%0d/%h", i, RegWrite, WriteReg, WriteData, 20 + i, 32'h2000 + i); end
      end
   endtask

   task automatic test_kill();
      step(1, 5'd3, 32'h33, 1, 5'd9, 32'hAA, 5'd9, '0);
      step(1, 5'd9, 32'hBB, 0, '0, '0, 5'd9, '0);
      nvec++; if (oP1 !== 1'b1) begin nfail++; $display("FAIL kill_pend_before got %b exp 1", oP1); end
      idle(5'd9);
      nvec++; if (oP1 !== 1'b0) begin nfail++; $display("FAIL kill_pend_after got %b exp 0", oP1); end
      nvec++; if (RegWrite !== 1'b0) begin nfail++; $display("FAIL kill_pop_rw got %b exp 0", RegWrite); end
      idle('0);
      nvec++; if (rf[9] !== 32'hBB) begin nfail++; $display("FAIL kill_final got %h exp bb", rf[9]); end
   endtask

   task automatic test_starve();
      repeat (DEPTH + 1) idle('0);
      step(1, 5'd1, 32'h1, 1, 5'd15, 32'h55, '0, '0);
      for (int k = 1; k <= 8; k++) begin
         step(1, 5'(k), 32'(k), 0, '0, '0, '0, '0);
         nvec++; if (StallReq !== (k == 8)) begin
            nfail++; $display("FAIL starve_k%0d got %b exp %b", k, StallReq, k == 8); end
      end
      idle('0);
      nvec++; if (RegWrite !== 1'b1 || WriteReg !== 5'd15) begin
         nfail++; $display("FAIL starve_pop got %b/%0d exp 1/15", RegWrite, WriteReg); end
      nvec++; if (StallReq !== 1'b0) begin nfail++; $display("FAIL starve_clear got %b exp 0", StallReq); end
   endtask

   task automatic test_zero();
      repeat (DEPTH + 1) idle('0);
      step(1, 5'd2, 32'h2, 1, 5'd7, 32'h77, '0, '0);
      step(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 5'd0, 5'd7);
      nvec++; if (oP1 !== 1'b0 || oP2 !== 1'b1) begin
         nfail++; $display("FAIL zero_pend got %b%b exp 01", oP1, oP2); end
      nvec++; if (RegWrite !== 1'b1 || WriteReg !== 5'd7) begin
         nfail++; $display("FAIL zero_pop got %b/%0d exp 1/7", RegWrite, WriteReg); end
      idle('0);
      nvec++; if (RegWrite !== 1'b0 || oReady !== 1'b1) begin
         nfail++; $display("FAIL zero_dropped got rw %b rdy %b exp 0 1", RegWrite, oReady); end
   endtask

   task automatic test_reset_mid();
      step(1, 5'd1, 32'h1, 1, 5'd16, 32'h16, '0, '0);
      step(1, 5'd2, 32'h2, 1, 5'd17, 32'h17, 5'd16, 5'd17);
      #2 Rst_n = 1'b0;
      #1;
      mreset();
      nvec++; if (RegWrite !== 1'b0 || WriteReg !== '0 || WriteData !== '0) begin
         nfail++; $display("FAIL rstmid_out got %b/%0d/%h exp 0/0/0", RegWrite, WriteReg, WriteData); end
      nvec++; if (MduReady !== 1'b1 || Pending1 !== 1'b0 || Pending2 !== 1'b0) begin
         nfail++; $display("FAIL rstmid_q got rdy %b p %b%b exp 1 00", MduReady, Pending1, Pending2); end
      @(posedge Clk); #1 Rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         idle(5'd16);
         nvec++; if (RegWrite !== 1'b0) begin nfail++; $display("FAIL rstmid_nowrite%0d got %b exp 0", i, RegWrite); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         int wp;
         wp = (c < 300) ? 90 : 40;
         step($urandom_range(99) < wp, 5'($urandom_range(7)), $urandom,
              $urandom_range(1), 5'($urandom_range(7)), $urandom,
              5'($urandom_range(7)), 5'($urandom_range(7)));
         nvec++; if (oReady !== eReady) begin nfail++; $display("FAIL rnd_ready c%0d got %b exp %b", c, oReady, eReady); end
         nvec++; if (oP1 !== eP1) begin nfail++; $display("FAIL rnd_p1 c%0d got %b exp %b", c, oP1, eP1); end
         nvec++; if (oP2 !== eP2) begin nfail++; $display("FAIL rnd_p2 c%0d got %b exp %b", c, oP2, eP2); end
         nvec++; if (RegWrite !== eRW) begin nfail++; $display("FAIL rnd_rw c%0d got %b exp %b", c, RegWrite, eRW); end
         nvec++; if (WriteReg !== eReg) begin nfail++; $display("FAIL rnd_wreg c%0d got %0d exp %0d", c, WriteReg, eReg); end
         nvec++; if (WriteData !== eData) begin nfail++; $display("FAIL rnd_wdata c%0d got %h exp %h", c, WriteData, eData); end
         nvec++; if (StallReq !== eStall) begin nfail++; $display("FAIL rnd_stall c%0d got %b exp %b", c, StallReq, eStall); end
      end
   endtask

   initial begin
      Rst_n = 1'b0;
      WbValid = 0; WbReg = '0; WbData = '0;
      MduValid = 0; MduReg = '0; MduData = '0;
      QueryReg1 = '0; QueryReg2 = '0;
      for (int i = 0; i < 32; i++) rf[i] = '0;
      mreset();
      repeat (2) @(posedge Clk);
      #1 Rst_n = 1'b1;
      test_reset();
      test_mdu_basic();
      test_back_to_back();
      test_kill();
      test_starve();
      test_zero();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
